// File: rtl/pkt_loader_pkg.sv
// pkt_loader_pkg
//   Shared types and constants for the packet loader: bus widths, default
//   packet length limits, loader FSM state encoding and the word address helper.
package pkt_loader_pkg;

   localparam int ADDR_W          = 32;
   localparam int DATA_W          = 32;
   localparam int LEN_W           = 16;
   localparam int DEF_MIN_PKT_LEN = 14;
   localparam int DEF_MAX_PKT_LEN = 1518;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_RECV,
      LD_START,
      LD_DONE,
      LD_DROP
   } ld_state_t;

   // Byte address of the word that holds byte number len (word_idx = len[15:2]).
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  len);
      return base + {{(ADDR_W-LEN_W){1'b0}}, len[LEN_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pkt_loader_packer.sv
// pkt_loader_packer
//   Packs bytes big-endian into a 32-bit word. The word/width outputs already
//   include the byte presented on data, so the caller can write the word out on
//   the same edge that accepts its final byte.
// Ports
//   clk, rst  clock, asynchronous active-high reset
//   push      accept data into the current word
//   flush     the pushed byte ends the word even if it is not the 4th
//   data      incoming byte
//   word      stored bytes plus data in its lane; lanes above it are 0
//   width     byte count of word including data (1..4)
//   full      data would be the 4th byte of the word
module pkt_loader_packer
   import pkt_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              flush,
   input  logic [7:0]        data,
   output logic [DATA_W-1:0] word,
   output logic [3:0]        width,
   output logic              full
);

   logic [DATA_W-1:0] word_reg;
   logic [1:0]        cnt_reg;

   // Lane gi is byte gi of the word; first byte lands in [31:24].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign word[DATA_W-1-8*gi -: 8] = (cnt_reg == 2'(gi)) ? data
                                                              : word_reg[DATA_W-1-8*gi -: 8];
      end
   endgenerate

   assign width = {2'b00, cnt_reg} + 4'd1;
   assign full  = (cnt_reg == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_reg <= '0;
         cnt_reg  <= '0;
      end else if (push) begin
         if (full || flush) begin
            word_reg <= '0;
            cnt_reg  <= '0;
         end else begin
            word_reg <= word;
            cnt_reg  <= cnt_reg + 2'd1;
         end
      end
   end

endmodule

// File: rtl/pkt_loader.sv
// pkt_loader
//   MAC ingress stage: packs the byte stream into 32-bit big-endian words,
//   writes them into the packet buffer, then hands a legal packet to the
//   header parser and reports its length. Runts are written but not parsed;
//   oversize packets are truncated at MAX_PKT_LEN and the tail is drained.
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   rx_valid_i/rx_data_i/rx_last_i byte stream from the MAC
//   rx_ready_o                     byte accepted when rx_valid_i & rx_ready_o
//   mem_ce_o/mem_we_o              packet buffer write strobe
//   mem_addr_o                     byte address of the word start
//   mem_width_o                    valid bytes in the write (1..4)
//   mem_data_o                     word, first byte in [31:24]
//   ps_start_o/ps_ready_i          parser handshake
//   done_o, pkt_len_o              packet parsed pulse and held length
//   err_runt_o, err_oversize_o     error pulses
module pkt_loader
   import pkt_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ZERO_ADDR,
   parameter int                MIN_PKT_LEN = DEF_MIN_PKT_LEN,
   parameter int                MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_last_i,
   output logic              rx_ready_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_width_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              ps_start_o,
   input  logic              ps_ready_i,
   output logic              done_o,
   output logic [LEN_W-1:0]  pkt_len_o,
   output logic              err_runt_o,
   output logic              err_oversize_o
);

   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PKT_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

   ld_state_t         state_reg, state_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic              rx_ready_reg, rx_ready_next;
   logic              mem_ce_reg, mem_ce_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [3:0]        mem_width_reg, mem_width_next;
   logic [DATA_W-1:0] mem_data_reg, mem_data_next;
   logic              ps_start_reg, ps_start_next;
   logic              done_reg, done_next;
   logic [LEN_W-1:0]  pkt_len_reg, pkt_len_next;
   logic              err_runt_reg, err_runt_next;
   logic              err_over_reg, err_over_next;

   logic              accept;
   logic [LEN_W-1:0]  len_inc;
   logic              pk_push, pk_flush, pk_full;
   logic [DATA_W-1:0] pk_word;
   logic [3:0]        pk_width;

   pkt_loader_packer u_packer (
      .clk   (clk),
      .rst   (rst),
      .push  (pk_push),
      .flush (pk_flush),
      .data  (rx_data_i),
      .word  (pk_word),
      .width (pk_width),
      .full  (pk_full)
   );

   assign accept  = rx_valid_i & rx_ready_reg;
   assign len_inc = len_reg + LEN_W'(1);

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      mem_ce_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_width_next = mem_width_reg;
      mem_data_next  = mem_data_reg;
      ps_start_next  = ps_start_reg;
      done_next      = 1'b0;
      pkt_len_next   = pkt_len_reg;
      err_runt_next  = 1'b0;
      err_over_next  = 1'b0;
      pk_push        = 1'b0;
      pk_flush       = 1'b0;

      case (state_reg)
         LD_IDLE, LD_RECV: begin
            if (accept) begin
               pk_push  = 1'b1;
               // Reaching MAX_LEN without last also closes the word so that
               // the truncated tail is still written before draining.
               pk_flush = rx_last_i | (len_inc == MAX_LEN);
               len_next = len_inc;
               if (pk_full || pk_flush) begin
                  mem_ce_next    = 1'b1;
                  mem_we_next    = 1'b1;
                  mem_addr_next  = word_addr(BASE_ADDR, len_reg);
                  mem_width_next = pk_width;
                  mem_data_next  = pk_word;
               end
               if (rx_last_i) begin
                  if (len_inc >= MIN_LEN) begin
                     ps_start_next = 1'b1;
                     state_next    = LD_START;
                  end else begin
                     err_runt_next = 1'b1;
                     len_next      = '0;
                     state_next    = LD_IDLE;
                  end
               end else if (len_inc == MAX_LEN) begin
                  state_next = LD_DROP;
               end else begin
                  state_next = LD_RECV;
               end
            end
         end
         LD_START: begin
            if (ps_ready_i) begin
               ps_start_next = 1'b0;
               done_next     = 1'b1;
               pkt_len_next  = len_reg;
               state_next    = LD_DONE;
            end
         end
         LD_DONE: begin
            len_next   = '0;
            state_next = LD_IDLE;
         end
         LD_DROP: begin
            // len stays saturated at MAX_LEN while the tail is discarded.
            if (accept && rx_last_i) begin
               err_over_next = 1'b1;
               len_next      = '0;
               state_next    = LD_IDLE;
            end
         end
         default: begin
            len_next   = '0;
            state_next = LD_IDLE;
         end
      endcase

      // Registered ready so that it reads 0 straight out of reset.
      rx_ready_next = (state_next == LD_IDLE) || (state_next == LD_RECV) ||
                      (state_next == LD_DROP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= LD_IDLE;
         len_reg       <= '0;
         rx_ready_reg  <= 1'b0;
         mem_ce_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= ZERO_ADDR;
         mem_width_reg <= '0;
         mem_data_reg  <= '0;
         ps_start_reg  <= 1'b0;
         done_reg      <= 1'b0;
         pkt_len_reg   <= '0;
         err_runt_reg  <= 1'b0;
         err_over_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         rx_ready_reg  <= rx_ready_next;
         mem_ce_reg    <= mem_ce_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_width_reg <= mem_width_next;
         mem_data_reg  <= mem_data_next;
         ps_start_reg  <= ps_start_next;
         done_reg      <= done_next;
         pkt_len_reg   <= pkt_len_next;
         err_runt_reg  <= err_runt_next;
         err_over_reg  <= err_over_next;
      end
   end

   assign rx_ready_o     = rx_ready_reg;
   assign mem_ce_o       = mem_ce_reg;
   assign mem_we_o       = mem_we_reg;
   assign mem_addr_o     = mem_addr_reg;
   assign mem_width_o    = mem_width_reg;
   assign mem_data_o     = mem_data_reg;
   assign ps_start_o     = ps_start_reg;
   assign done_o         = done_reg;
   assign pkt_len_o      = pkt_len_reg;
   assign err_runt_o     = err_runt_reg;
   assign err_oversize_o = err_over_reg;

endmodule

// File: tb/tb_pkt_loader.sv
// tb_pkt_loader
//   Table-driven bench for pkt_loader (MIN 14, MAX 64). Expected buffer writes
//   are queued when a packet is driven and compared as the DUT emits them.
module tb_pkt_loader;
   import pkt_loader_pkg::*;

   localparam int MINL = 14;
   localparam int MAXL = 64;
   localparam int K_PARSE = 0;
   localparam int K_RUNT  = 1;
   localparam int K_OVER  = 2;

   logic        clk;
   logic        rst;
   logic        rx_valid_i, rx_last_i, ps_ready_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o, mem_ce_o, mem_we_o, ps_start_o, done_o;
   logic [31:0] mem_addr_o, mem_data_o;
   logic [3:0]  mem_width_o;
   logic [15:0] pkt_len_o;
   logic        err_runt_o, err_oversize_o;

   pkt_loader #(.BASE_ADDR(32'h0), .MIN_PKT_LEN(MINL), .MAX_PKT_LEN(MAXL)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid_i     (rx_valid_i),
      .rx_data_i      (rx_data_i),
      .rx_last_i      (rx_last_i),
      .rx_ready_o     (rx_ready_o),
      .mem_ce_o       (mem_ce_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_width_o    (mem_width_o),
      .mem_data_o     (mem_data_o),
      .ps_start_o     (ps_start_o),
      .ps_ready_i     (ps_ready_i),
      .done_o         (done_o),
      .pkt_len_o      (pkt_len_o),
      .err_runt_o     (err_runt_o),
      .err_oversize_o (err_oversize_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  width;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int n;
      int gap;
      int kind;
   } vec_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          wr_seen = 0, cnt_runt = 0, cnt_over = 0, cnt_done = 0, cnt_start = 0;
   logic [31:0] capt [0:31];
   logic [7:0]  pkt  [0:127];
   vec_t        vt   [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pulse counters and scoreboard for buffer writes.
   always @(negedge clk) begin
      if (ps_start_o)     cnt_start++;
      if (done_o)         cnt_done++;
      if (err_runt_o)     cnt_runt++;
      if (err_oversize_o) cnt_over++;
      if (done_o) chk("ce_during_done", 32'(mem_ce_o), 32'd0);
      if (mem_ce_o) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wr_unexpected: got write addr %h width %0d data %h, required none",
                     mem_addr_o, mem_width_o, mem_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_we",    32'(mem_we_o),    32'd1);
            chk("wr_addr",  mem_addr_o,       mon_e.addr);
            chk("wr_width", 32'(mem_width_o), 32'(mon_e.width));
            chk("wr_data",  mem_data_o,       mon_e.data);
            capt[mem_addr_o[6:2]] = mem_data_o;
         end
      end
   end

   // Expected writes for the first wn bytes of pkt.
   task automatic push_exp(input int wn);
      wr_t e;
      for (int w = 0; 4*w < wn; w++) begin
         e.addr  = 32'(4*w);
         e.width = (wn - 4*w >= 4) ? 4'd4 : 4'(wn - 4*w);
         e.data  = '0;
         for (int b = 0; b < int'(e.width); b++) e.data[31-8*b -: 8] = pkt[4*w+b];
         exp_q.push_back(e);
      end
   endtask

   task automatic fill_pkt(input int v, input int n);
      for (int i = 0; i < n; i++) pkt[i] = 8'((i*13 + v*29 + 1) & 8'hff);
   endtask

   task automatic fill_frame1();
      for (int i = 0; i < 60; i++) pkt[i] = 8'(i);
      pkt[12] = 8'h08;
      pkt[13] = 8'h00;
   endtask

   // Drive n bytes; returns the number of cycles the DUT stalled a valid byte.
   task automatic send(input int n, input int gap, input bit with_last, output int stalls);
      bit acc;
      int guard;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            rx_valid_i = 1'b0;
            @(posedge clk); #1;
         end
         rx_valid_i = 1'b1;
         rx_data_i  = pkt[i];
         rx_last_i  = with_last && (i == n-1);
         guard = 0;
         do begin
            acc = rx_ready_o;
            @(posedge clk); #1;
            if (!acc) stalls++;
            guard++;
         end while (!acc && guard < 100);
         if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_accept: byte %0d not accepted, required acceptance within 100 cycles", i);
         end
      end
      rx_valid_i = 1'b0;
      rx_last_i  = 1'b0;
   endtask

   task automatic run_vec(input int v, input int n, input int gap, input int kind);
      int stalls, wn, g;
      int d_start, d_done, d_runt, d_over, d_wr;
      wn      = (n > MAXL) ? MAXL : n;
      d_start = cnt_start; d_done = cnt_done; d_runt = cnt_runt;
      d_over  = cnt_over;  d_wr   = wr_seen;
      push_exp(wn);
      send(n, gap, 1'b1, stalls);
      if (kind == K_PARSE) begin
         @(negedge clk);
         chk("start_hi", 32'(ps_start_o), 32'd1);
         rx_valid_i = 1'b1;
         rx_data_i  = 8'hAA;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ready_in_start", 32'(rx_ready_o), 32'd0);
            chk("start_held",     32'(ps_start_o), 32'd1);
         end
         @(posedge clk); #1;
         rx_valid_i = 1'b0;
         ps_ready_i = 1'b1;
         g = 0;
         do begin @(negedge clk); g++; end while (!done_o && g < 20);
         chk("done_pulse", 32'(done_o),  32'd1);
         chk("pkt_len",    32'(pkt_len_o), 32'(n));
         @(posedge clk); #1;
         ps_ready_i = 1'b0;
         @(negedge clk);
         chk("done_one_cycle", 32'(done_o),     32'd0);
         chk("start_low",      32'(ps_start_o), 32'd0);
         chk("pkt_len_held",   32'(pkt_len_o),  32'(n));
         chk("done_count",     32'(cnt_done - d_done), 32'd1);
      end else begin
         repeat (3) @(negedge clk);
         chk("no_start", 32'(cnt_start - d_start), 32'd0);
         if (kind == K_RUNT) begin
            chk("runt_pulse", 32'(cnt_runt - d_runt), 32'd1);
         end else begin
            chk("over_pulse", 32'(cnt_over - d_over), 32'd1);
            chk("no_stall",   32'(stalls), 32'd0);
         end
      end
      chk("writes", 32'(wr_seen - d_wr), 32'((wn + 3) / 4));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("pkt %0d: len %0d gap %0d kind %0d writes %0d stalls %0d",
               v, n, gap, kind, wr_seen - d_wr, stalls);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   int d_done0;

   initial begin
      vt[0]  = '{60, 0,  K_PARSE};
      vt[1]  = '{61, 0,  K_PARSE};
      vt[2]  = '{10, 0,  K_RUNT};
      vt[3]  = '{70, 0,  K_OVER};
      vt[4]  = '{60, 30, K_PARSE};
      vt[5]  = '{14, 0,  K_PARSE};
      vt[6]  = '{13, 0,  K_RUNT};
      vt[7]  = '{64, 0,  K_PARSE};
      vt[8]  = '{65, 0,  K_OVER};
      vt[9]  = '{1,  0,  K_RUNT};
      vt[10] = '{16, 0,  K_PARSE};
      vt[11] = '{20, 25, K_PARSE};

      rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_data_i = 8'h00; ps_ready_i = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready",  32'(rx_ready_o),  32'd0);
      chk("rst_ce",     32'(mem_ce_o),    32'd0);
      chk("rst_addr",   mem_addr_o,       32'd0);
      chk("rst_start",  32'(ps_start_o),  32'd0);
      chk("rst_done",   32'(done_o),      32'd0);
      chk("rst_len",    32'(pkt_len_o),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 12; v++) begin
         if (vt[v].n == 60) fill_frame1();
         else               fill_pkt(v, vt[v].n);
         run_vec(v, vt[v].n, vt[v].gap, vt[v].kind);
         if (v == 0) chk("addr12_data", capt[3], 32'h0800_0E0F);
         if (v == 1) chk("addr60_data", capt[15], {pkt[60], 24'h0});
      end

      // ps_ready_i while idle must not produce a done pulse.
      d_done0 = cnt_done;
      ps_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 ps_ready_i = 1'b0;
      @(negedge clk);
      chk("ready_idle_ignored", 32'(cnt_done - d_done0), 32'd0);
      chk("ready_idle_start",   32'(ps_start_o), 32'd0);
      $display("pkt idle_ps_ready: done pulses %0d", cnt_done - d_done0);

      // Reset after byte 7: only the first full word reaches the buffer.
      begin
         int st;
         fill_pkt(40, 8);
         push_exp(4);
         send(7, 0, 1'b0, st);
         #2 rst = 1'b1;
         #1;
         chk("mid_rst_ready", 32'(rx_ready_o),     32'd0);
         chk("mid_rst_ce",    32'(mem_ce_o),       32'd0);
         chk("mid_rst_we",    32'(mem_we_o),       32'd0);
         chk("mid_rst_addr",  mem_addr_o,          32'd0);
         chk("mid_rst_width", 32'(mem_width_o),    32'd0);
         chk("mid_rst_data",  mem_data_o,          32'd0);
         chk("mid_rst_start", 32'(ps_start_o),     32'd0);
         chk("mid_rst_len",   32'(pkt_len_o),      32'd0);
         chk("mid_rst_errs",  32'({err_runt_o, err_oversize_o, done_o}), 32'd0);
         chk("mid_rst_queue", 32'(exp_q.size()),   32'd0);
         $display("pkt reset_mid: 7 bytes then reset");
         @(negedge clk);
         rst = 1'b0;
         @(posedge clk); #1;
      end
      fill_pkt(41, 20);
      run_vec(12, 20, 0, K_PARSE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
